limn2600_mem_arbiter: RTL and testbench
=======================================

Name: limn2600_mem_arbiter

Overview:
- Round-robin arbiter sharing the single-port limn2600 SRAM/ROM/NVRAM memory block between NUM_MASTERS requesters: instruction fetch, load/store, and a future DMA/serial engine.
- Serialises requests into single-cycle chip-select strobes on the memory port.
- Waits for the memory's rdy pulse, then returns read data and a completion pulse to the granted requester.
- Sits between the CPU/bus masters and the memory; the memory side connects directly to the SRAM's cs/we/addr/data_in/data_out/rdy.

Parameters:
- DATA_WIDTH, 32, data bus width per master and to memory.
- NUM_MASTERS, 3, number of requesters (2..8); index 0 is highest tie-break after reset.
- TIMEOUT_CYCLES, 64, WAIT-state cycle limit; used only with LIMN_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- m_req  in  NUM_MASTERS  per-master request level; held until that master's m_rdy.
- m_we  in  NUM_MASTERS  per-master write enable, valid while m_req is high.
- m_addr  in  32*NUM_MASTERS  flattened byte addresses; master i occupies [32*i+31:32*i].
- m_wdata  in  DATA_WIDTH*NUM_MASTERS  flattened write data.
- m_rdy  out  NUM_MASTERS  one-hot completion pulse, one cycle long.
- m_rdata  out  DATA_WIDTH  read data, shared by all masters; valid when any m_rdy bit is high.
- m_err  out  NUM_MASTERS  timeout error pulse, coincident with m_rdy.
- mem_cs  out  1  memory chip select; single-cycle strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdy  in  1  memory completion pulse.
- mem_rdata  in  DATA_WIDTH  memory read data.
- busy  out  1  high in every state other than IDLE.

Behaviour:
- Reset (asynchronous, rst=1):
  - All outputs go to 0: mem_cs, mem_we, mem_addr, mem_wdata, m_rdy, m_rdata, m_err, busy.
  - State goes to IDLE, the round-robin pointer to 0, and the timeout counter to 0.
  - Reset asserted mid-transaction abandons it and no m_rdy is issued. Masters must re-request after rst falls.
- States are IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- IDLE:
  - If any m_req bit is high, grant the first requesting index at or after the pointer, scanning upward and wrapping modulo NUM_MASTERS.
  - Latch the granted master's we/addr/wdata into the mem_* registers, set mem_cs=1, and go to ISSUE.
  - With no request, stay in IDLE with mem_cs=0.
- ISSUE: mem_cs is high for exactly this one cycle. Next cycle mem_cs=0 and the state goes to WAIT.
- WAIT:
  - On mem_rdy=1, capture mem_rdata into m_rdata (writes also capture it; the SRAM returns 0).
  - Set m_rdy[grant]=1 and go to DONE.
- DONE:
  - m_rdy is high for this one cycle.
  - The pointer updates to (grant+1) mod NUM_MASTERS, then the state returns to IDLE.
  - m_rdy clears on the next cycle; m_rdata holds its value until the next capture.
- Latency: a request sampled in IDLE at edge N gives mem_cs high in cycle N+1 and mem_rdy in cycle N+2. m_rdy is high in cycle N+3.
- Throughput: one transaction per 4 cycles (IDLE, ISSUE, WAIT, DONE).
- Fairness: every continuously requesting master is served within NUM_MASTERS transactions.
- Simultaneous requests: round-robin order; the pointer advances only on completion.
- A master deasserting m_req before its m_rdy is a protocol violation. The granted transaction still completes and the m_rdy pulse is still emitted.
- The arbiter ignores mem_rdy outside WAIT.
- The arbiter does not check address alignment or decode addresses; both pass through unchanged.

Optional Feature:
- LIMN_ARB_TIMEOUT_EN defined:
  - A counter runs in WAIT, reset on entry.
  - When it reaches TIMEOUT_CYCLES without mem_rdy, the arbiter sets m_rdata=32'hDEADBEEF, m_rdy[grant]=1 and m_err[grant]=1, and goes to DONE.
  - A mem_rdy arriving in the same cycle as the limit takes precedence, and no error is raised.
- LIMN_ARB_TIMEOUT_EN undefined: no counter exists, m_err is tied to 0, and WAIT waits indefinitely.

Decomposition:
- Shared package limn2600_pkg holds:
  - the state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DONE=2'd3);
  - the TIMEOUT_DATA constant 32'hDEADBEEF;
  - the memory map constants ROM_BASE=32'hFFFE0000, NVRAM_BASE=32'hF8000000, RAM_BASE=32'h00000000.
- One sub-module, limn2600_rr_pick: a combinational round-robin priority picker.
  - Inputs: req vector and pointer.
  - Outputs: one-hot grant and binary index.
  - Verified standalone.

Test Plan:
- Single read: master1 requests a read of addr 0x00000010 (RAM preloaded with 0x12345678). Expect mem_cs high for exactly 1 cycle; m_rdy[1] 3 cycles after request sampling; m_rdata=0x12345678.
- Contention: all 3 masters request continuously from reset. Expect grant order 0,1,2,0,1,2 with one completion every 4 cycles, and mem_cs never high for two consecutive cycles.
- Write then read: master0 writes 0xCAFEF00D to 0x00000020, then master2 reads it. Expect m_rdata=0xCAFEF00D and mem_we=1 only during the write's ISSUE cycle.
- Reset mid-transaction: assert rst asynchronously during WAIT. Expect all outputs 0 immediately, no m_rdy pulse, pointer back to 0, and the next grant going to the lowest requesting index.
- Timeout (LIMN_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): memory model suppresses mem_rdy. Expect m_rdy[g]=m_err[g]=1 and m_rdata=0xDEADBEEF exactly 8 WAIT cycles in.
- Timeout boundary: the same bench with mem_rdy on cycle 8. Expect m_err=0 and the real data returned.

Source files
------------

// File: rtl/limn2600_pkg.sv
// limn2600 shared package: arbiter state encoding, timeout data pattern and
// the memory map base addresses of the limn2600 SRAM/ROM/NVRAM block.
package limn2600_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } arb_state_e;

  // Read data returned to a master whose access timed out.
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

  localparam logic [31:0] ROM_BASE   = 32'hFFFE0000;
  localparam logic [31:0] NVRAM_BASE = 32'hF8000000;
  localparam logic [31:0] RAM_BASE   = 32'h00000000;

endpackage

// File: rtl/limn2600_rr_pick.sv
// Combinational round-robin priority picker.
// Grants the first requesting index at or after the pointer, scanning upward
// and wrapping modulo NUM_MASTERS.
// Ports:
//   i_req  request vector
//   i_ptr  round-robin pointer (highest priority index), must be < NUM_MASTERS
//   o_gnt  one-hot grant (all zero when nothing requests)
//   o_idx  binary index of the granted requester (0 when nothing requests)
module limn2600_rr_pick #(
  parameter int unsigned NUM_MASTERS = 3
) (
  input  logic [NUM_MASTERS-1:0]         i_req,
  input  logic [$clog2(NUM_MASTERS)-1:0] i_ptr,
  output logic [NUM_MASTERS-1:0]         o_gnt,
  output logic [$clog2(NUM_MASTERS)-1:0] o_idx
);

  localparam int unsigned IdxW = $clog2(NUM_MASTERS);

  always_comb begin
    int unsigned      cand;
    logic [IdxW-1:0]  w_cand;
    logic             found;
    o_gnt = '0;
    o_idx = '0;
    found = 1'b0;
    cand  = 0;
    w_cand = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      cand = 32'(i_ptr) + k;
      if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
      w_cand = IdxW'(cand);
      if (!found && i_req[w_cand]) begin
        found         = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
      end
    end
  end

endmodule

// File: rtl/limn2600_mem_arbiter.sv
// Round-robin arbiter sharing the single-port limn2600 memory block between
// NUM_MASTERS requesters. Each transaction runs IDLE -> ISSUE -> WAIT -> DONE:
// a one-cycle mem_cs strobe, a wait for mem_rdy, then a one-cycle m_rdy pulse
// to the granted master with read data on the shared m_rdata bus.
// Optional build macro: LIMN_ARB_TIMEOUT_EN enables a WAIT-state timeout of
// TIMEOUT_CYCLES cycles that completes the access with m_err and TIMEOUT_DATA.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   m_req/m_we/m_addr/m_wdata per-master request level, write enable, address,
//                            write data (flattened, master i in slice i)
//   m_rdy/m_err/m_rdata      one-hot completion and error pulses, shared data
//   mem_cs/mem_we/mem_addr/mem_wdata  memory request (cs is a 1-cycle strobe)
//   mem_rdy/mem_rdata        memory completion pulse and read data
//   busy                     high whenever the FSM is not idle
module limn2600_mem_arbiter
  import limn2600_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_MASTERS    = 3,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            m_req,
  input  logic [NUM_MASTERS-1:0]            m_we,
  input  logic [32*NUM_MASTERS-1:0]         m_addr,
  input  logic [DATA_WIDTH*NUM_MASTERS-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]            m_rdy,
  output logic [DATA_WIDTH-1:0]             m_rdata,
  output logic [NUM_MASTERS-1:0]            m_err,
  output logic                              mem_cs,
  output logic                              mem_we,
  output logic [31:0]                       mem_addr,
  output logic [DATA_WIDTH-1:0]             mem_wdata,
  input  logic                              mem_rdy,
  input  logic [DATA_WIDTH-1:0]             mem_rdata,
  output logic                              busy
);

  localparam int unsigned IdxW = $clog2(NUM_MASTERS);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8) begin : g_bad_num_masters
    $error("NUM_MASTERS must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  arb_state_e r_state, w_state_d;

  logic [IdxW-1:0]        r_ptr, w_ptr_d;
  logic [IdxW-1:0]        r_grant_idx, w_grant_idx_d;
  logic [NUM_MASTERS-1:0] r_grant, w_grant_d;
  logic                   r_mem_cs, w_mem_cs_d;
  logic                   r_mem_we, w_mem_we_d;
  logic [31:0]            r_mem_addr, w_mem_addr_d;
  logic [DATA_WIDTH-1:0]  r_mem_wdata, w_mem_wdata_d;
  logic [NUM_MASTERS-1:0] r_m_rdy, w_m_rdy_d;
  logic [DATA_WIDTH-1:0]  r_m_rdata, w_m_rdata_d;
  logic [NUM_MASTERS-1:0] w_m_err_d;
  logic                   r_busy, w_busy_d;
  logic                   w_tmo_hit;

  logic [NUM_MASTERS-1:0] w_pick_gnt;
  logic [IdxW-1:0]        w_pick_idx;

  limn2600_rr_pick #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_rr_pick (
    .i_req(m_req),
    .i_ptr(r_ptr),
    .o_gnt(w_pick_gnt),
    .o_idx(w_pick_idx)
  );

`ifdef LIMN_ARB_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TmoW-1:0]        r_tmo, w_tmo_d;
  logic [NUM_MASTERS-1:0] r_m_err;

  // Counter is zero in every non-WAIT state, so it restarts on each WAIT entry.
  assign w_tmo_hit = (r_tmo == TmoW'(TIMEOUT_CYCLES - 1));
  assign w_tmo_d   = (r_state == StWait) ? r_tmo + 1'b1 : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo   <= '0;
      r_m_err <= '0;
    end else begin
      r_tmo   <= w_tmo_d;
      r_m_err <= w_m_err_d;
    end
  end

  assign m_err = r_m_err;
`else
  assign w_tmo_hit = 1'b0;
  assign m_err     = '0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (|m_req) w_state_d = StIssue;
      StIssue: w_state_d = StWait;
      StWait:  if (mem_rdy || w_tmo_hit) w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs and grant bookkeeping.
  always_comb begin
    w_ptr_d       = r_ptr;
    w_grant_idx_d = r_grant_idx;
    w_grant_d     = r_grant;
    w_mem_cs_d    = 1'b0;
    w_mem_we_d    = 1'b0;
    w_mem_addr_d  = r_mem_addr;
    w_mem_wdata_d = r_mem_wdata;
    w_m_rdy_d     = '0;
    w_m_rdata_d   = r_m_rdata;
    w_m_err_d     = '0;
    w_busy_d      = (w_state_d != StIdle);
    unique case (r_state)
      StIdle: begin
        if (|m_req) begin
          w_grant_idx_d = w_pick_idx;
          w_grant_d     = w_pick_gnt;
          w_mem_cs_d    = 1'b1;
          w_mem_we_d    = m_we[w_pick_idx];
          w_mem_addr_d  = m_addr[32*w_pick_idx +: 32];
          w_mem_wdata_d = m_wdata[DATA_WIDTH*w_pick_idx +: DATA_WIDTH];
        end
      end
      StWait: begin
        // A real response wins over a timeout expiring in the same cycle.
        if (mem_rdy) begin
          w_m_rdata_d = mem_rdata;
          w_m_rdy_d   = r_grant;
        end else if (w_tmo_hit) begin
          w_m_rdata_d = DATA_WIDTH'(TIMEOUT_DATA);
          w_m_rdy_d   = r_grant;
          w_m_err_d   = r_grant;
        end
      end
      StDone: begin
        w_ptr_d = (r_grant_idx == IdxW'(NUM_MASTERS - 1)) ? '0 : r_grant_idx + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_grant_idx <= '0;
      r_grant     <= '0;
      r_mem_cs    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_m_rdy     <= '0;
      r_m_rdata   <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_ptr       <= w_ptr_d;
      r_grant_idx <= w_grant_idx_d;
      r_grant     <= w_grant_d;
      r_mem_cs    <= w_mem_cs_d;
      r_mem_we    <= w_mem_we_d;
      r_mem_addr  <= w_mem_addr_d;
      r_mem_wdata <= w_mem_wdata_d;
      r_m_rdy     <= w_m_rdy_d;
      r_m_rdata   <= w_m_rdata_d;
      r_busy      <= w_busy_d;
    end
  end

  assign mem_cs    = r_mem_cs;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign m_rdy     = r_m_rdy;
  assign m_rdata   = r_m_rdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_limn2600_mem_arbiter.sv
// Directed bench for limn2600_mem_arbiter: table of single transactions plus
// hand-written contention, reset-abort, stray-rdy and stalled-memory sequences.
module tb_limn2600_mem_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned DW = 32;

  logic            clk;
  logic            rst;
  logic [N-1:0]    m_req;
  logic [N-1:0]    m_we;
  logic [32*N-1:0] m_addr;
  logic [DW*N-1:0] m_wdata;
  logic [N-1:0]    m_rdy;
  logic [DW-1:0]   m_rdata;
  logic [N-1:0]    m_err;
  logic            mem_cs;
  logic            mem_we;
  logic [31:0]     mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_rdy;
  logic [DW-1:0]   mem_rdata;
  logic            busy;

  limn2600_mem_arbiter #(
    .DATA_WIDTH(DW),
    .NUM_MASTERS(N),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .m_req(m_req),
    .m_we(m_we),
    .m_addr(m_addr),
    .m_wdata(m_wdata),
    .m_rdy(m_rdy),
    .m_rdata(m_rdata),
    .m_err(m_err),
    .mem_cs(mem_cs),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdy(mem_rdy),
    .mem_rdata(mem_rdata),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: responds rdy_delay cycles after the cs cycle (0 = never).
  logic [31:0] mem [64];
  int          rdy_delay;
  int          wcnt;
  bit          active;
  logic        model_rdy;
  logic        spur_rdy;

  assign mem_rdy = model_rdy | spur_rdy;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[0]    <= 32'h11110000;
      mem[1]    <= 32'h22221111;
      mem[2]    <= 32'h33332222;
      mem[4]    <= 32'h12345678;
      mem[5]    <= 32'hA5A55A5A;
      model_rdy <= 1'b0;
      active    <= 1'b0;
      wcnt      <= 0;
      mem_rdata <= '0;
    end else begin
      model_rdy <= 1'b0;
      if (mem_cs) begin
        if (mem_we) begin
          mem[mem_addr[7:2]] <= mem_wdata;
          mem_rdata          <= '0;
        end else begin
          mem_rdata <= mem[mem_addr[7:2]];
        end
        if (rdy_delay == 1) model_rdy <= 1'b1;
        else if (rdy_delay > 1) begin
          active <= 1'b1;
          wcnt   <= 1;
        end
      end else if (active) begin
        if (wcnt + 1 == rdy_delay) begin
          model_rdy <= 1'b1;
          active    <= 1'b0;
        end else begin
          wcnt <= wcnt + 1;
        end
      end
    end
  end

  int n_checks;
  int n_errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  typedef struct {
    int          m;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    int          lat;
    bit          err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic run_txn(input vec_t v);
    int          lat;
    int          cs_n;
    int          we_n;
    bit          got;
    logic [31:0] addr_cs;
    logic [31:0] wdata_cs;
    logic [N-1:0] rdy_s;
    logic [N-1:0] err_s;
    logic [31:0] rd_s;
    lat = 0; cs_n = 0; we_n = 0; got = 0;
    addr_cs = '0; wdata_cs = '0; rdy_s = '0; err_s = '0; rd_s = '0;
    rdy_delay                  = v.delay;
    m_we[v.m]                  = v.we;
    m_addr[32*v.m +: 32]       = v.addr;
    m_wdata[DW*v.m +: DW]      = v.wdata;
    m_req[v.m]                 = 1'b1;
    while (!got && lat < 40) begin
      tick();
      lat++;
      if (mem_cs) begin
        cs_n++;
        addr_cs  = mem_addr;
        wdata_cs = mem_wdata;
      end
      if (mem_we) we_n++;
      if (m_rdy != '0) begin
        got   = 1;
        rdy_s = m_rdy;
        err_s = m_err;
        rd_s  = m_rdata;
      end
    end
    chk("txn_latency", lat, v.lat);
    chk("txn_m_rdy", 32'(rdy_s), 32'(1 << v.m));
    chk("txn_m_err", 32'(err_s), v.err ? 32'(1 << v.m) : 32'h0);
    chk("txn_m_rdata", rd_s, v.rdata);
    chk("txn_cs_cycles", cs_n, 1);
    chk("txn_we_cycles", we_n, 32'(v.we));
    chk("txn_mem_addr", addr_cs, v.addr);
    chk("txn_mem_wdata", wdata_cs, v.wdata);
    m_req[v.m] = 1'b0;
    m_we[v.m]  = 1'b0;
    tick();
    chk("txn_rdy_clear", 32'(m_rdy), 32'h0);
    chk("txn_busy_clear", 32'(busy), 32'h0);
    chk("txn_rdata_hold", m_rdata, v.rdata);
    rdy_delay = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int order[$];
    int when[$];
    logic [31:0] rds[$];
    int   cyc;
    int   consec;
    bit   prev_cs;
    bit   seen;
    logic [31:0] exp_rd [3];
    int   rdy_seen;

    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    m_req     = '0;
    m_we      = '0;
    m_addr    = '0;
    m_wdata   = '0;
    spur_rdy  = 1'b0;
    rdy_delay = 1;

    // {m, we, addr, wdata, delay, latency, err, rdata}
    vecs.push_back('{1, 0, 32'h10, 32'h0,        1, 3,  0, 32'h12345678});
    vecs.push_back('{0, 1, 32'h20, 32'hCAFEF00D, 1, 3,  0, 32'h00000000});
    vecs.push_back('{2, 0, 32'h20, 32'h0,        1, 3,  0, 32'hCAFEF00D});
    vecs.push_back('{0, 0, 32'h14, 32'h0,        1, 3,  0, 32'hA5A55A5A});
    vecs.push_back('{2, 1, 32'h14, 32'h0BADF00D, 1, 3,  0, 32'h00000000});
    vecs.push_back('{1, 0, 32'h14, 32'h0,        1, 3,  0, 32'h0BADF00D});
    // Response in the 8th WAIT cycle: real data, no error in either build.
    vecs.push_back('{1, 0, 32'h10, 32'h0,        8, 10, 0, 32'h12345678});
`ifdef LIMN_ARB_TIMEOUT_EN
    vecs.push_back('{2, 0, 32'h20, 32'h0,        0, 10, 1, 32'hDEADBEEF});
`endif

    tick();
    tick();
    chk("reset_mem_cs", 32'(mem_cs), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_m_rdy", 32'(m_rdy), 32'h0);
    chk("reset_m_rdata", m_rdata, 32'h0);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) run_txn(vecs[i]);

    // Contention: all masters request continuously from reset.
    rst = 1'b1;
    exp_rd[0] = 32'h11110000;
    exp_rd[1] = 32'h22221111;
    exp_rd[2] = 32'h33332222;
    for (int i = 0; i < N; i++) m_addr[32*i +: 32] = 32'(4 * i);
    m_req = '1;
    tick();
    rst = 1'b0;
    cyc = 0; consec = 0; prev_cs = 0;
    while (order.size() < 6 && cyc < 60) begin
      tick();
      cyc++;
      if (mem_cs && prev_cs) consec++;
      prev_cs = mem_cs;
      if (m_rdy != '0) begin
        order.push_back(onehot_idx(m_rdy));
        when.push_back(cyc);
        rds.push_back(m_rdata);
      end
    end
    m_req = '0;
    chk("cont_completions", order.size(), 6);
    chk("cont_cs_back_to_back", consec, 0);
    for (int i = 0; i < order.size(); i++) begin
      chk("cont_order", order[i], i % 3);
      chk("cont_rdata", rds[i], exp_rd[i % 3]);
      if (i > 0) chk("cont_spacing", when[i] - when[i-1], 4);
    end
    tick();
    tick();

    // Reset mid-transaction: pointer is 1 after serving m0, so m2 wins first.
    run_txn('{0, 0, 32'h0, 32'h0, 1, 3, 0, 32'h11110000});
    m_addr[0 +: 32]  = 32'h00;
    m_addr[64 +: 32] = 32'h08;
    rdy_delay = 0;
    m_req = 3'b101;
    tick();
    chk("rr_grant_after_ptr", mem_addr, 32'h08);
    tick();
    tick();
    chk("abort_busy_before", 32'(busy), 32'h1);
    #3;
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_mem_cs", 32'(mem_cs), 32'h0);
    chk("abort_mem_we", 32'(mem_we), 32'h0);
    chk("abort_mem_addr", mem_addr, 32'h0);
    chk("abort_mem_wdata", mem_wdata, 32'h0);
    chk("abort_m_rdy", 32'(m_rdy), 32'h0);
    chk("abort_m_rdata", m_rdata, 32'h0);
    chk("abort_m_err", 32'(m_err), 32'h0);
    rdy_seen = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      if (m_rdy != '0) rdy_seen++;
    end
    rdy_delay = 1;
    rst = 1'b0;
    seen = 0; cyc = 0;
    while (!seen && cyc < 20) begin
      tick();
      cyc++;
      if (m_rdy != '0) rdy_seen++;
      if (mem_cs) begin
        seen = 1;
        chk("abort_regrant_addr", mem_addr, 32'h00);
      end
    end
    chk("abort_no_stray_rdy", rdy_seen, 0);
    chk("abort_regrant_seen", 32'(seen), 32'h1);
    seen = 0; cyc = 0;
    while (!seen && cyc < 20) begin
      tick();
      cyc++;
      if (m_rdy != '0) begin
        seen = 1;
        chk("abort_regrant_rdy", 32'(m_rdy), 32'h1);
        chk("abort_regrant_rdata", m_rdata, 32'h11110000);
      end
    end
    chk("abort_regrant_done", 32'(seen), 32'h1);
    m_req = '0;
    tick();
    tick();

    // Stray mem_rdy while idle must be ignored.
    spur_rdy = 1'b1;
    tick();
    spur_rdy = 1'b0;
    tick();
    chk("stray_rdy_m_rdy", 32'(m_rdy), 32'h0);
    chk("stray_rdy_busy", 32'(busy), 32'h0);
    chk("stray_rdy_rdata", m_rdata, 32'h11110000);

`ifndef LIMN_ARB_TIMEOUT_EN
    // Without the timeout the arbiter waits indefinitely for mem_rdy.
    rdy_delay = 0;
    m_addr[32 +: 32] = 32'h04;
    m_req = 3'b010;
    rdy_seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (m_rdy != '0 || m_err != '0) rdy_seen++;
    end
    chk("stall_no_rdy", rdy_seen, 0);
    chk("stall_busy", 32'(busy), 32'h1);
    spur_rdy = 1'b1;
    tick();
    spur_rdy = 1'b0;
    chk("stall_release_rdy", 32'(m_rdy), 32'h2);
    chk("stall_release_err", 32'(m_err), 32'h0);
    chk("stall_release_rdata", m_rdata, 32'h22221111);
    m_req = '0;
    rdy_delay = 1;
    tick();
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
